sram_1rw_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for a single-port bit-masked SRAM macro (1 read/write port, one access per cycle, read data undefined after a write). It presents two independent valid/ready request ports and per-port buffered read-response ports, and drives the macro's `re`/`we`/`addr`/`data_in`/`wmask` pins. It sits between two clients (e.g. a DMA engine and a CPU-side port) and one SRAM instance.

---
 rtl/sram_1rw_arbiter_if.sv | 51 +++++
 rtl/sram_1rw_arbiter.sv | 128 ++++++++++++
 tb/tb_sram_1rw_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_1rw_arbiter_if.sv
// Bundle of the two client request/response ports and the SRAM macro pins.
// The slave modport is the arbiter's view; master is the clients plus the macro.
interface sram_1rw_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic                  p0_req_valid;
    logic                  p0_req_ready;
    logic                  p0_req_write;
    logic [ADDR_WIDTH-1:0] p0_req_addr;
    logic [DATA_WIDTH-1:0] p0_req_wdata;
    logic [DATA_WIDTH-1:0] p0_req_wmask;
    logic                  p0_rsp_valid;
    logic                  p0_rsp_ready;
    logic [DATA_WIDTH-1:0] p0_rsp_data;

    logic                  p1_req_valid;
    logic                  p1_req_ready;
    logic                  p1_req_write;
    logic [ADDR_WIDTH-1:0] p1_req_addr;
    logic [DATA_WIDTH-1:0] p1_req_wdata;
    logic [DATA_WIDTH-1:0] p1_req_wmask;
    logic                  p1_rsp_valid;
    logic                  p1_rsp_ready;
    logic [DATA_WIDTH-1:0] p1_rsp_data;

    logic                  mem_re;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_wmask;
    logic [DATA_WIDTH-1:0] mem_data_out;

    modport slave (
        input  p0_req_valid, p0_req_write, p0_req_addr, p0_req_wdata, p0_req_wmask, p0_rsp_ready,
        output p0_req_ready, p0_rsp_valid, p0_rsp_data,
        input  p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata, p1_req_wmask, p1_rsp_ready,
        output p1_req_ready, p1_rsp_valid, p1_rsp_data,
        output mem_re, mem_we, mem_addr, mem_data_in, mem_wmask,
        input  mem_data_out
    );

    modport master (
        output p0_req_valid, p0_req_write, p0_req_addr, p0_req_wdata, p0_req_wmask, p0_rsp_ready,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_data,
        output p1_req_valid, p1_req_write, p1_req_addr, p1_req_wdata, p1_req_wmask, p1_rsp_ready,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_data,
        input  mem_re, mem_we, mem_addr, mem_data_in, mem_wmask,
        output mem_data_out
    );
endinterface

// File: rtl/sram_1rw_arbiter.sv
// Round-robin arbiter for two valid/ready clients sharing one single-port
// bit-masked SRAM, with a one-entry read-response buffer per client.
module sram_1rw_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_b,
    sram_1rw_arbiter_if.slave bus
);
    logic [1:0]            req_valid;
    logic [1:0]            req_write;
    logic [1:0]            rsp_ready;
    logic [ADDR_WIDTH-1:0] req_addr  [2];
    logic [DATA_WIDTH-1:0] req_wdata [2];
    logic [DATA_WIDTH-1:0] req_wmask [2];

    logic [1:0]            elig;
    logic [1:0]            grant;
    logic [1:0]            rd_inflight;
    logic                  any_grant;
    logic                  win;

    logic                  mem_re;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_wmask;

    logic                  last_grant_q, last_grant_d;
    logic                  rd_pending_q, rd_pending_d;
    logic                  rd_port_q,    rd_port_d;
    logic [1:0]            rsp_valid_q,  rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q [2];
    logic [DATA_WIDTH-1:0] rsp_data_d [2];

    assign req_valid    = {bus.p1_req_valid, bus.p0_req_valid};
    assign req_write    = {bus.p1_req_write, bus.p0_req_write};
    assign rsp_ready    = {bus.p1_rsp_ready, bus.p0_rsp_ready};
    assign req_addr[0]  = bus.p0_req_addr;
    assign req_addr[1]  = bus.p1_req_addr;
    assign req_wdata[0] = bus.p0_req_wdata;
    assign req_wdata[1] = bus.p1_req_wdata;
    assign req_wmask[0] = bus.p0_req_wmask;
    assign req_wmask[1] = bus.p1_req_wmask;

    // A read is in flight only during the single cycle after its grant.
    assign rd_inflight = {rd_pending_q & rd_port_q, rd_pending_q & ~rd_port_q};

    always_comb begin
        elig         = '0;
        grant        = '0;
        mem_re       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        mem_wmask    = '0;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;

        // rst_b gates grants so the macro pins are quiet while reset is held.
        for (int k = 0; k < 2; k++) begin
            elig[k] = rst_b && req_valid[k] &&
                      (req_write[k] || (!rd_inflight[k] && (!rsp_valid_q[k] || rsp_ready[k])));
        end
        grant[0]  = elig[0] && (!elig[1] || last_grant_q);
        grant[1]  = elig[1] && (!elig[0] || !last_grant_q);
        any_grant = |grant;
        win       = grant[1];

        if (any_grant) begin
            mem_addr = req_addr[win];
            if (req_write[win]) begin
                mem_we      = 1'b1;
                mem_data_in = req_wdata[win];
                mem_wmask   = req_wmask[win];
            end else begin
                mem_re      = 1'b1;
            end
        end

        last_grant_d = any_grant ? win : last_grant_q;
        rd_pending_d = any_grant && !req_write[win];
        rd_port_d    = rd_pending_d ? win : rd_port_q;

        // Capture wins over drain so a back-to-back read is never lost.
        for (int k = 0; k < 2; k++) begin
            if (rsp_valid_q[k] && rsp_ready[k]) begin
                rsp_valid_d[k] = 1'b0;
            end
            if (rd_inflight[k]) begin
                rsp_valid_d[k] = 1'b1;
                rsp_data_d[k]  = bus.mem_data_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last_grant_q  <= 1'b1;
            rd_pending_q  <= 1'b0;
            rd_port_q     <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_data_q[0] <= '0;
            rsp_data_q[1] <= '0;
        end else begin
            last_grant_q  <= last_grant_d;
            rd_pending_q  <= rd_pending_d;
            rd_port_q     <= rd_port_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q[0] <= rsp_data_d[0];
            rsp_data_q[1] <= rsp_data_d[1];
        end
    end

    assign bus.p0_req_ready = grant[0];
    assign bus.p1_req_ready = grant[1];
    assign bus.p0_rsp_valid = rsp_valid_q[0];
    assign bus.p1_rsp_valid = rsp_valid_q[1];
    assign bus.p0_rsp_data  = rsp_data_q[0];
    assign bus.p1_rsp_data  = rsp_data_q[1];
    assign bus.mem_re       = mem_re;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_data_in  = mem_data_in;
    assign bus.mem_wmask    = mem_wmask;
endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Bench for sram_1rw_arbiter: SRAM macro model, scoreboard monitor driven by a
// spec-level reference (shadow memory, response queues), directed and random stimulus.
module tb_sram_1rw_arbiter;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    sram_1rw_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_1rw_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // SRAM macro: read data one cycle after re, garbage after a write.
    logic [DW-1:0] sram [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) sram[i] = '0;
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_data_out <= sram[bus.mem_addr];
        else if (bus.mem_we) bus.mem_data_out <= DW'($urandom);
        if (bus.mem_we)
            sram[bus.mem_addr] = (sram[bus.mem_addr] & ~bus.mem_wmask) | (bus.mem_data_in & bus.mem_wmask);
    end

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exq0 [$];
    logic [DW-1:0] exq1 [$];
    logic          m_last = 1'b1;
    logic [1:0]    m_infl = '0;
    logic [1:0]    m_full = '0;
    int            cyc = 0;
    int            gcnt [2] = '{0, 0};
    int            gcyc [2] = '{0, 0};
    initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    logic [1:0]    mv, mw, mrr, me, meg, mg;
    logic [AW-1:0] ma [2];
    logic [DW-1:0] md [2];
    logic [DW-1:0] mm [2];
    logic [22:0]   pins_exp;
    int            mwin;

    always @(negedge clk) begin
        cyc++;
        if (!rst_b) begin
            exq0.delete();
            exq1.delete();
            m_last = 1'b1;
            m_infl = '0;
            m_full = '0;
        end else begin
            mv  = {bus.p1_req_valid, bus.p0_req_valid};
            mw  = {bus.p1_req_write, bus.p0_req_write};
            mrr = {bus.p1_rsp_ready, bus.p0_rsp_ready};
            ma[0] = bus.p0_req_addr;  ma[1] = bus.p1_req_addr;
            md[0] = bus.p0_req_wdata; md[1] = bus.p1_req_wdata;
            mm[0] = bus.p0_req_wmask; mm[1] = bus.p1_req_wmask;
            for (int k = 0; k < 2; k++)
                me[k] = mv[k] && (mw[k] || (!m_infl[k] && (!m_full[k] || mrr[k])));
            // Tie goes to the port that did not win last time.
            meg[0] = me[0] && (!me[1] || m_last == 1'b1);
            meg[1] = me[1] && (!me[0] || m_last == 1'b0);
            mg = {bus.p1_req_ready, bus.p0_req_ready};
            chk("grant", 64'(mg), 64'(meg));

            mwin = mg[0] ? 0 : 1;
            pins_exp = '0;
            if (mg != 2'b00) begin
                if (mw[mwin]) pins_exp = {1'b0, 1'b1, ma[mwin], md[mwin], mm[mwin]};
                else          pins_exp = {1'b1, 1'b0, ma[mwin], 8'h00, 8'h00};
            end
            chk("mem_pins", 64'({bus.mem_re, bus.mem_we, bus.mem_addr, bus.mem_data_in, bus.mem_wmask}),
                64'(pins_exp));

            if (m_full[0]) begin
                chk("p0_rsp_valid", 64'(bus.p0_rsp_valid), 64'(1));
                if (exq0.size() > 0) chk("p0_rsp_data", 64'(bus.p0_rsp_data), 64'(exq0[0]));
                if (mrr[0]) begin
                    if (exq0.size() > 0) void'(exq0.pop_front());
                    m_full[0] = 1'b0;
                end
            end else chk("p0_rsp_valid", 64'(bus.p0_rsp_valid), 64'(0));
            if (m_full[1]) begin
                chk("p1_rsp_valid", 64'(bus.p1_rsp_valid), 64'(1));
                if (exq1.size() > 0) chk("p1_rsp_data", 64'(bus.p1_rsp_data), 64'(exq1[0]));
                if (mrr[1]) begin
                    if (exq1.size() > 0) void'(exq1.pop_front());
                    m_full[1] = 1'b0;
                end
            end else chk("p1_rsp_valid", 64'(bus.p1_rsp_valid), 64'(0));

            for (int k = 0; k < 2; k++) if (m_infl[k]) m_full[k] = 1'b1;
            m_infl = '0;
            if (mg != 2'b00) begin
                gcnt[mwin]++;
                gcyc[mwin] = cyc;
                m_last = mwin[0];
                if (mw[mwin]) begin
                    ref_mem[ma[mwin]] = (ref_mem[ma[mwin]] & ~mm[mwin]) | (md[mwin] & mm[mwin]);
                end else begin
                    m_infl[mwin] = 1'b1;
                    if (mwin == 0) exq0.push_back(ref_mem[ma[0]]);
                    else           exq1.push_back(ref_mem[ma[1]]);
                end
            end
        end
    end

    task automatic set_port(input int k, input logic v, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] m);
        if (k == 0) begin
            bus.p0_req_valid = v; bus.p0_req_write = wr; bus.p0_req_addr = a;
            bus.p0_req_wdata = d; bus.p0_req_wmask = m;
        end else begin
            bus.p1_req_valid = v; bus.p1_req_write = wr; bus.p1_req_addr = a;
            bus.p1_req_wdata = d; bus.p1_req_wmask = m;
        end
    endtask

    // Hold a request until granted (bounded), then drop valid after that edge.
    task automatic req(input int k, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] m);
        bit got;
        got = 1'b0;
        set_port(k, 1'b1, wr, a, d, m);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((k == 0) ? bus.p0_req_ready : bus.p1_req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL req_timeout port %0d: got no grant, required a grant within 200 cycles", k);
        end
        @(posedge clk);
        #1;
        set_port(k, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Read, then check the buffered response two cycles after the grant.
    task automatic rd(input int k, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        req(k, 1'b0, a, '0, '0);
        @(posedge clk);
        #1;
        chk("rd_lat_valid", 64'((k == 0) ? bus.p0_rsp_valid : bus.p1_rsp_valid), 64'(1));
        chk("rd_data", 64'((k == 0) ? bus.p0_rsp_data : bus.p1_rsp_data), 64'(exp));
    endtask

    task automatic rnd_port(input int k);
        repeat (150) begin
            if ($urandom_range(3) != 0)
                req(k, 1'($urandom_range(1)), AW'($urandom_range(7)), DW'($urandom), DW'($urandom));
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    function automatic logic [42:0] all_outs();
        return {bus.p0_req_ready, bus.p1_req_ready, bus.p0_rsp_valid, bus.p1_rsp_valid,
                bus.p0_rsp_data, bus.p1_rsp_data, bus.mem_re, bus.mem_we,
                bus.mem_addr, bus.mem_data_in, bus.mem_wmask};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish within 500000 time units");
        $fatal(1, "watchdog expired");
    end

    int  rr_g0, rr_g1, we_cnt;
    bit  rnd_on;

    initial begin
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
        bus.p0_rsp_ready = 1'b1;
        bus.p1_rsp_ready = 1'b1;

        // Reset state with a request pending: nothing may leak out.
        set_port(0, 1'b1, 1'b1, 5'd9, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(all_outs()), 64'(0));
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        rst_b = 1'b1;

        // Reset mid-read discards the in-flight read.
        req(0, 1'b1, 5'd4, 8'h44, 8'hFF);
        set_port(0, 1'b1, 1'b0, 5'd4, '0, '0);
        @(negedge clk);
        chk("mid_rd_grant", 64'(bus.p0_req_ready), 64'(1));
        @(posedge clk);
        #3;
        rst_b = 1'b0;
        #1;
        chk("async_reset_outputs", 64'(all_outs()), 64'(0));
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", 64'(bus.p0_rsp_valid), 64'(0));

        // Simultaneous writes after reset: p0 first, p1 the next cycle.
        fork
            req(0, 1'b1, 5'd6, 8'h66, 8'hFF);
            req(1, 1'b1, 5'd7, 8'h77, 8'hFF);
        join
        chk("tie_order", 64'(gcyc[1] - gcyc[0]), 64'(1));

        // Write then read back.
        req(0, 1'b1, 5'd5, 8'hA5, 8'hFF);
        rd(0, 5'd5, 8'hA5);

        // Masked writes, including an all-zero mask.
        req(1, 1'b1, 5'd3, 8'hFF, 8'hFF);
        req(1, 1'b1, 5'd3, 8'h00, 8'h0F);
        rd(1, 5'd3, 8'hF0);
        req(1, 1'b1, 5'd3, 8'h5A, 8'h00);
        rd(1, 5'd3, 8'hF0);

        // Continuous writes on both ports for 8 cycles.
        rr_g0 = gcnt[0];
        rr_g1 = gcnt[1];
        we_cnt = 0;
        set_port(0, 1'b1, 1'b1, 5'd8, 8'h01, 8'hFF);
        set_port(1, 1'b1, 1'b1, 5'd9, 8'h02, 8'hFF);
        repeat (8) begin
            @(negedge clk);
            we_cnt += int'(bus.mem_we);
        end
        @(posedge clk);
        #1;
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
        chk("rr_p0_count", 64'(gcnt[0] - rr_g0), 64'(4));
        chk("rr_p1_count", 64'(gcnt[1] - rr_g1), 64'(4));
        chk("rr_we_cycles", 64'(we_cnt), 64'(8));

        // Backpressure on p0's response buffer.
        req(0, 1'b1, 5'd1, 8'h11, 8'hFF);
        bus.p0_rsp_ready = 1'b0;
        rd(0, 5'd1, 8'h11);
        set_port(0, 1'b1, 1'b0, 5'd2, '0, '0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_read_blocked", 64'(bus.p0_req_ready), 64'(0));
        end
        chk("bp_data_held", 64'(bus.p0_rsp_data), 64'(8'h11));
        @(posedge clk);
        #1;
        set_port(0, 1'b1, 1'b1, 5'd2, 8'h22, 8'hFF);
        @(negedge clk);
        chk("bp_write_granted", 64'(bus.p0_req_ready), 64'(1));
        @(posedge clk);
        #1;
        set_port(0, 1'b1, 1'b0, 5'd2, '0, '0);
        @(negedge clk);
        chk("bp_still_blocked", 64'(bus.p0_req_ready), 64'(0));
        @(posedge clk);
        #1;
        bus.p0_rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_same_cycle", 64'(bus.p0_req_ready), 64'(1));
        @(posedge clk);
        #1;
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;

        // p0 read addr 2, p1 overwrites addr 2 the next cycle.
        fork
            rd(0, 5'd2, 8'h22);
            begin
                @(posedge clk);
                #1;
                req(1, 1'b1, 5'd2, 8'h5C, 8'hFF);
            end
        join
        rd(0, 5'd2, 8'h5C);

        // Random traffic with random response backpressure.
        rnd_on = 1'b1;
        fork
            begin
                fork
                    rnd_port(0);
                    rnd_port(1);
                join
                rnd_on = 1'b0;
            end
            while (rnd_on) begin
                @(posedge clk);
                #1;
                bus.p0_rsp_ready = 1'($urandom);
                bus.p1_rsp_ready = 1'($urandom);
            end
        join
        bus.p0_rsp_ready = 1'b1;
        bus.p1_rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_p0", 64'(exq0.size()), 64'(0));
        chk("drain_p1", 64'(exq1.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
